// File: rtl/fetch_unit.sv
// Instruction fetch unit: single-outstanding request FSM (IDLE/REQ/HOLD/DRAIN) holding one word for the decoder.
// Optional `FETCH_PERF_CNT_EN adds a 32-bit fetch_count output counting accepted instructions.
module fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [5:0]  opCode,
    output logic [31:0] instr_pc,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_target
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] fetch_count
`endif
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        HOLD  = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t      state;
    state_t      state_next;
    logic [31:0] pc;
    logic [31:0] pc_next;
    logic        capture;
    logic [31:0] instr_q;
    logic [31:0] instr_pc_q;
    logic [31:0] redirect_pc;

    assign redirect_pc = redirect_target & ~32'd3;

    always_comb begin
        state_next = state;
        pc_next    = pc;
        capture    = 1'b0;
        unique case (state)
            IDLE: state_next = REQ;
            REQ: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    // Without a response yet, the old request is still in flight and must be drained.
                    state_next = imem_valid ? REQ : DRAIN;
                end else if (imem_valid) begin
                    capture    = 1'b1;
                    state_next = HOLD;
                end
            end
            HOLD: begin
                if (redirect_valid) begin
                    pc_next    = redirect_pc;
                    state_next = REQ;
                end else if (instr_ready) begin
                    pc_next    = pc + 32'd4;
                    state_next = REQ;
                end
            end
            DRAIN: begin
                if (redirect_valid) begin
                    pc_next = redirect_pc;
                end
                // A response arriving together with a new redirect still retires the stale request.
                if (imem_valid) begin
                    state_next = REQ;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            pc         <= RESET_PC;
            instr_q    <= 32'd0;
            instr_pc_q <= 32'd0;
        end else begin
            state <= state_next;
            pc    <= pc_next;
            if (capture) begin
                instr_q    <= imem_rdata;
                instr_pc_q <= pc;
            end
        end
    end

    // Outputs are forced low while reset is asserted so nothing leaks before the first edge.
    assign imem_req    = !reset && (state == REQ);
    assign imem_addr   = (reset || state == IDLE) ? 32'd0 : pc;
    assign instr_valid = !reset && (state == HOLD);
    assign instr       = reset ? 32'd0 : instr_q;
    assign instr_pc    = reset ? 32'd0 : instr_pc_q;
    assign opCode      = instr[31:26];

`ifdef FETCH_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_count <= 32'd0;
        end else if (state == HOLD && instr_ready && !redirect_valid) begin
            fetch_count <= fetch_count + 32'd1;
        end
    end
`endif

endmodule
